// File: rtl/ws2812_pkg.sv
// ----------------------------------------------------------------------------
// ws2812_pkg
// Shared types and default timing constants for the WS2812 single-wire NRZ
// receiver (ws2812_rx) and its pulse-measurement front end.
//
// Contents:
//   rx_state_t   - line-tracking FSM state (IDLE, HIGH, LOW, ERR)
//   grb_t        - one pixel as received, green first, MSB first
//   WS_*         - default cycle counts at a 12 MHz system clock
//
// Optional feature macro used by the files importing this package:
//   WS2812_RX_PASSTHRU_EN
// ----------------------------------------------------------------------------
package ws2812_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2,
        ERR  = 2'd3
    } rx_state_t;

    typedef struct packed {
        logic [7:0] g;
        logic [7:0] r;
        logic [7:0] b;
    } grb_t;

    // Defaults for a 12 MHz clock, matching the transmitter's bit timing.
    localparam int WS_CLK_HZ         = 12_000_000;
    localparam int WS_MIN_HIGH       = 2;
    localparam int WS_BIT_THRESH     = 6;
    localparam int WS_MAX_HIGH       = 14;
    localparam int WS_RESET_CYCLES   = 600;   // 50 us low ends a frame
    localparam int WS_MAX_PIXELS     = 64;    // 8x8 grid
    localparam int WS_BITS_PER_PIXEL = 24;

endpackage : ws2812_pkg

// File: rtl/ws2812_pulse_meas.sv
// ----------------------------------------------------------------------------
// ws2812_pulse_meas
// Front end of the WS2812 receiver: synchronizes the serial line, detects
// edges and measures high/low widths. Each high pulse is classified and
// reported to the pixel assembler as a single-cycle event.
//
// Ports:
//   clk_i        in   system clock
//   rst_ni       in   synchronous active-low reset
//   din_i        in   asynchronous WS2812 line
//   din_d_o      out  synchronized line delayed one clk (only with
//                     WS2812_RX_PASSTHRU_EN defined)
//   bit_valid_o  out  pulse: a data bit was decoded, value on bit_val_o
//   bit_val_o    out  decoded bit value (held between pulses)
//   glitch_o     out  pulse: runt high pulse discarded
//   too_long_o   out  pulse: high pulse exceeded MAX_HIGH cycles
//   gap_o        out  pulse: low time reached RESET_CYCLES
//
// Timing: a din edge launched just after clock edge N is acted on at edge
// N+3 (two synchronizer flops plus the previous-sample compare). The counter
// values therefore equal the true pulse width in cycles.
// ----------------------------------------------------------------------------
module ws2812_pulse_meas
    import ws2812_pkg::*;
#(
    parameter int MIN_HIGH     = WS_MIN_HIGH,
    parameter int BIT_THRESH   = WS_BIT_THRESH,
    parameter int MAX_HIGH     = WS_MAX_HIGH,
    parameter int RESET_CYCLES = WS_RESET_CYCLES
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic din_i,
`ifdef WS2812_RX_PASSTHRU_EN
    output logic din_d_o,
`endif
    output logic bit_valid_o,
    output logic bit_val_o,
    output logic glitch_o,
    output logic too_long_o,
    output logic gap_o
);

    // hi_cnt must hold MAX_HIGH+1, lo_cnt must hold RESET_CYCLES.
    localparam int HI_W = $clog2(MAX_HIGH + 2);
    localparam int LO_W = $clog2(RESET_CYCLES + 1);

    localparam logic [HI_W-1:0] MIN_C  = HI_W'(MIN_HIGH);
    localparam logic [HI_W-1:0] THR_C  = HI_W'(BIT_THRESH);
    localparam logic [HI_W-1:0] MAXH_C = HI_W'(MAX_HIGH);
    localparam logic [LO_W-1:0] GAP_C  = LO_W'(RESET_CYCLES);

    logic            sync1_q;
    logic            sync2_q;   // din_s
    logic            prev_q;    // din_s one cycle ago
    logic            rise;
    logic            fall;

    rx_state_t       state_q;
    logic [HI_W-1:0] hi_cnt_q;
    logic [LO_W-1:0] lo_cnt_q;

    logic            bit_valid_q;
    logic            bit_val_q;
    logic            glitch_q;
    logic            too_long_q;
    logic            gap_q;

    assign rise = sync2_q & ~prev_q;
    assign fall = ~sync2_q & prev_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            prev_q      <= 1'b0;
            state_q     <= IDLE;
            hi_cnt_q    <= '0;
            lo_cnt_q    <= '0;
            bit_valid_q <= 1'b0;
            bit_val_q   <= 1'b0;
            glitch_q    <= 1'b0;
            too_long_q  <= 1'b0;
            gap_q       <= 1'b0;
        end else begin
            sync1_q     <= din_i;
            sync2_q     <= sync1_q;
            prev_q      <= sync2_q;
            bit_valid_q <= 1'b0;
            glitch_q    <= 1'b0;
            too_long_q  <= 1'b0;
            gap_q       <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (rise) begin
                        hi_cnt_q <= HI_W'(1);
                        state_q  <= HIGH;
                    end
                end

                HIGH: begin
                    if (fall) begin
                        // hi_cnt here equals the number of high cycles seen.
                        if (hi_cnt_q < MIN_C) begin
                            glitch_q <= 1'b1;
                        end else begin
                            bit_valid_q <= 1'b1;
                            bit_val_q   <= (hi_cnt_q >= THR_C);
                        end
                        lo_cnt_q <= LO_W'(1);
                        state_q  <= LOW;
                    end else if (hi_cnt_q >= MAXH_C) begin
                        // Still high past MAX_HIGH: saturate and report once.
                        hi_cnt_q   <= MAXH_C + HI_W'(1);
                        too_long_q <= 1'b1;
                        state_q    <= ERR;
                    end else begin
                        hi_cnt_q <= hi_cnt_q + HI_W'(1);
                    end
                end

                LOW: begin
                    if (rise) begin
                        hi_cnt_q <= HI_W'(1);
                        state_q  <= HIGH;
                    end else if (lo_cnt_q >= GAP_C - LO_W'(1)) begin
                        lo_cnt_q <= GAP_C;
                        gap_q    <= 1'b1;
                        state_q  <= IDLE;
                    end else begin
                        lo_cnt_q <= lo_cnt_q + LO_W'(1);
                    end
                end

                ERR: begin
                    // Only a falling edge leaves ERR; the following reset gap
                    // then resynchronizes the frame.
                    if (fall) begin
                        lo_cnt_q <= LO_W'(1);
                        state_q  <= LOW;
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef WS2812_RX_PASSTHRU_EN
    assign din_d_o = prev_q;
`endif
    assign bit_valid_o = bit_valid_q;
    assign bit_val_o   = bit_val_q;
    assign glitch_o    = glitch_q;
    assign too_long_o  = too_long_q;
    assign gap_o       = gap_q;

endmodule : ws2812_pulse_meas

// File: rtl/ws2812_rx.sv
// ----------------------------------------------------------------------------
// ws2812_rx
// WS2812 NRZ receiver. Decodes the serial LED stream into 24-bit GRB pixels,
// numbers them within the frame, and flags frame end and protocol errors.
//
// Ports:
//   clk          in   system clock
//   rst_n        in   synchronous active-low reset
//   din          in   asynchronous WS2812 serial line
//   pixel_valid  out  one-cycle pulse: pixel_grb / pixel_idx updated
//   pixel_grb    out  G[23:16] R[15:8] B[7:0], MSB received first (held)
//   pixel_idx    out  index of the pixel within the frame (held)
//   frame_done   out  one-cycle pulse on a reset gap that followed >= 1 bit
//   err_glitch   out  one-cycle pulse on a runt high pulse
//   err_long     out  one-cycle pulse when a high pulse exceeds MAX_HIGH
//   dout         out  daisy-chain output, only with WS2812_RX_PASSTHRU_EN:
//                     low until pixel 0 of the frame is consumed, then the
//                     delayed line until frame end or reset
//
// Configuration macro: WS2812_RX_PASSTHRU_EN (undefined = no dout port).
// ----------------------------------------------------------------------------
module ws2812_rx
    import ws2812_pkg::*;
#(
    parameter int CLK_HZ       = WS_CLK_HZ,
    parameter int MIN_HIGH     = WS_MIN_HIGH,
    parameter int BIT_THRESH   = WS_BIT_THRESH,
    parameter int MAX_HIGH     = WS_MAX_HIGH,
    parameter int RESET_CYCLES = WS_RESET_CYCLES,
    parameter int MAX_PIXELS   = WS_MAX_PIXELS
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          din,
    output logic                          pixel_valid,
    output logic [23:0]                   pixel_grb,
    output logic [$clog2(MAX_PIXELS)-1:0] pixel_idx,
    output logic                          frame_done,
    output logic                          err_glitch,
`ifdef WS2812_RX_PASSTHRU_EN
    output logic                          err_long,
    output logic                          dout
`else
    output logic                          err_long
`endif
);

    localparam int IDX_W = $clog2(MAX_PIXELS);
    localparam int BC_W  = $clog2(WS_BITS_PER_PIXEL);

    localparam logic [BC_W-1:0]  LAST_BIT = BC_W'(WS_BITS_PER_PIXEL - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAX_PIXELS - 1);

    // Parameter sanity: the classification windows must be ordered.
    if (CLK_HZ < 1) begin : g_bad_clk_hz
        $error("ws2812_rx: CLK_HZ must be positive");
    end
    if (!(MIN_HIGH >= 1 && MIN_HIGH <= BIT_THRESH && BIT_THRESH <= MAX_HIGH)) begin : g_bad_timing
        $error("ws2812_rx: need 1 <= MIN_HIGH <= BIT_THRESH <= MAX_HIGH");
    end

    logic bit_valid;
    logic bit_val;
    logic glitch;
    logic too_long;
    logic gap;
`ifdef WS2812_RX_PASSTHRU_EN
    logic din_d;
`endif

    ws2812_pulse_meas #(
        .MIN_HIGH     (MIN_HIGH),
        .BIT_THRESH   (BIT_THRESH),
        .MAX_HIGH     (MAX_HIGH),
        .RESET_CYCLES (RESET_CYCLES)
    ) u_meas (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .din_i       (din),
`ifdef WS2812_RX_PASSTHRU_EN
        .din_d_o     (din_d),
`endif
        .bit_valid_o (bit_valid),
        .bit_val_o   (bit_val),
        .glitch_o    (glitch),
        .too_long_o  (too_long),
        .gap_o       (gap)
    );

    // ------------------------------------------------------------------
    // Pixel assembler
    // ------------------------------------------------------------------
    grb_t             shift_q,       shift_d;
    logic [BC_W-1:0]  bit_cnt_q,     bit_cnt_d;
    logic [IDX_W-1:0] idx_q,         idx_d;        // index of next pixel
    logic             frame_any_q,   frame_any_d;  // any bit since last gap
    logic             pixel_valid_q, pixel_valid_d;
    grb_t             pixel_grb_q,   pixel_grb_d;
    logic [IDX_W-1:0] pixel_idx_q,   pixel_idx_d;  // index of reported pixel
    logic             frame_done_q,  frame_done_d;

    always_comb begin
        shift_d       = shift_q;
        bit_cnt_d     = bit_cnt_q;
        idx_d         = idx_q;
        frame_any_d   = frame_any_q;
        pixel_valid_d = 1'b0;
        pixel_grb_d   = pixel_grb_q;
        pixel_idx_d   = pixel_idx_q;
        frame_done_d  = 1'b0;

        if (bit_valid) begin
            shift_d     = {shift_q[22:0], bit_val};
            frame_any_d = 1'b1;
            if (bit_cnt_q == LAST_BIT) begin
                pixel_valid_d = 1'b1;
                pixel_grb_d   = shift_d;
                pixel_idx_d   = idx_q;
                bit_cnt_d     = '0;
                idx_d         = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
            end else begin
                bit_cnt_d = bit_cnt_q + BC_W'(1);
            end
        end

        // A stuck-high pulse corrupts the current pixel; drop its bits.
        if (too_long) begin
            bit_cnt_d = '0;
        end

        // Reset gap: partial pixels are dropped, numbering restarts.
        if (gap) begin
            frame_done_d = frame_any_q;
            frame_any_d  = 1'b0;
            bit_cnt_d    = '0;
            idx_d        = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shift_q       <= '0;
            bit_cnt_q     <= '0;
            idx_q         <= '0;
            frame_any_q   <= 1'b0;
            pixel_valid_q <= 1'b0;
            pixel_grb_q   <= '0;
            pixel_idx_q   <= '0;
            frame_done_q  <= 1'b0;
        end else begin
            shift_q       <= shift_d;
            bit_cnt_q     <= bit_cnt_d;
            idx_q         <= idx_d;
            frame_any_q   <= frame_any_d;
            pixel_valid_q <= pixel_valid_d;
            pixel_grb_q   <= pixel_grb_d;
            pixel_idx_q   <= pixel_idx_d;
            frame_done_q  <= frame_done_d;
        end
    end

    assign pixel_valid = pixel_valid_q;
    assign pixel_grb   = pixel_grb_q;
    assign pixel_idx   = pixel_idx_q;
    assign frame_done  = frame_done_q;
    // Error pulses are already registered in the front end.
    assign err_glitch  = glitch;
    assign err_long    = too_long;

`ifdef WS2812_RX_PASSTHRU_EN
    // ------------------------------------------------------------------
    // Daisy-chain forwarding: pixel 0 is ours, everything after it is
    // repeated downstream until the frame ends.
    // ------------------------------------------------------------------
    logic fwd_q;
    logic dout_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fwd_q  <= 1'b0;
            dout_q <= 1'b0;
        end else begin
            if (gap) begin
                fwd_q <= 1'b0;
            end else if (pixel_valid_d && (idx_q == '0)) begin
                fwd_q <= 1'b1;
            end
            dout_q <= fwd_q & din_d;
        end
    end

    assign dout = dout_q;
`endif

endmodule : ws2812_rx

// File: tb/tb_ws2812_rx.sv
// ----------------------------------------------------------------------------
// tb_ws2812_rx
// Directed bench for ws2812_rx: drives WS2812 waveforms (1 = 9 high / 6 low,
// 0 = 4 high / 11 low, gap = 700 low) and checks decoded pixels, indices,
// frame/error pulses and key latencies against hand-computed values.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ws2812_rx;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic        clk = 1'b0;
    logic        rst_n;
    logic        din;
    logic        pixel_valid;
    logic [23:0] pixel_grb;
    logic [5:0]  pixel_idx;
    logic        frame_done;
    logic        err_glitch;
    logic        err_long;
`ifdef WS2812_RX_PASSTHRU_EN
    logic        dout;
`endif

    always #5 clk = ~clk;

    ws2812_rx dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .din         (din),
        .pixel_valid (pixel_valid),
        .pixel_grb   (pixel_grb),
        .pixel_idx   (pixel_idx),
        .frame_done  (frame_done),
        .err_glitch  (err_glitch),
`ifdef WS2812_RX_PASSTHRU_EN
        .err_long    (err_long),
        .dout        (dout)
`else
        .err_long    (err_long)
`endif
    );

    // ------------------------------------------------------------------
    // Scoreboard state
    // ------------------------------------------------------------------
    logic [31:0] exp_q[$];   // {2'b0, idx, grb}
    logic [31:0] got_q[$];
    int n_cmp = 0;
    int n_mis = 0;
    int pe_cnt = 0;
    int fd_cnt = 0;
    int gl_cnt = 0;
    int el_cnt = 0;
    int coinc_cnt = 0;
    int pv_edge = -1;
    int el_edge = -1;

    always @(posedge clk) pe_cnt = pe_cnt + 1;

    always @(negedge clk) begin
        if (pixel_valid) begin
            got_q.push_back({2'b00, pixel_idx, pixel_grb});
            pv_edge = pe_cnt;
        end
        if (frame_done) fd_cnt++;
        if (err_glitch) gl_cnt++;
        if (err_long) begin
            el_cnt++;
            el_edge = pe_cnt;
        end
        if (pixel_valid && frame_done) coinc_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_pixels(input string tag);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            check({tag, "_pixel"}, got_q.pop_front(), exp_q.pop_front());
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic check_events(input string tag, input int e_fd, input int e_gl, input int e_el);
        check({tag, "_frame_done"}, fd_cnt, e_fd);
        check({tag, "_err_glitch"}, gl_cnt, e_gl);
        check({tag, "_err_long"},   el_cnt, e_el);
        fd_cnt = 0;
        gl_cnt = 0;
        el_cnt = 0;
    endtask

    // ------------------------------------------------------------------
    // Driver tasks (called #1 after a rising edge, return #1 after one)
    // ------------------------------------------------------------------
    task automatic level(input logic v, input int n);
        din = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        if (b) begin
            level(1'b1, 9);
            level(1'b0, 6);
        end else begin
            level(1'b1, 4);
            level(1'b0, 11);
        end
    endtask

    task automatic send_bits(input logic [23:0] p, input int nbits);
        for (int i = 23; i > 23 - nbits; i--) send_bit(p[i]);
    endtask

    task automatic send_pixel(input logic [23:0] p);
        send_bits(p, 24);
    endtask

    task automatic send_gap();
        level(1'b0, 700);
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        int start;
        logic [23:0] v;
        logic [23:0] p0;

        rst_n = 1'b0;
        din   = 1'b0;
        repeat (5) @(posedge clk);
        #1;

        // Reset state
        check("rst_pixel_valid", pixel_valid, 0);
        check("rst_pixel_grb",   pixel_grb,   0);
        check("rst_pixel_idx",   pixel_idx,   0);
        check("rst_frame_done",  frame_done,  0);
        check("rst_err_glitch",  err_glitch,  0);
        check("rst_err_long",    err_long,    0);
`ifdef WS2812_RX_PASSTHRU_EN
        check("rst_dout", dout, 0);
`endif
        rst_n = 1'b1;
        level(1'b0, 20);
        check_events("idle_low", 0, 0, 0);

        // Single pixel 0x00FF00, with last-bit -> pixel_valid latency check.
        p0 = 24'h00FF00;
        exp_q.push_back({2'b00, 6'd0, p0});
        send_bits(p0, 23);
        start = pe_cnt;
        send_bit(p0[0]);
        // Last 0-bit: high 4 cycles, falling edge seen at +7, pixel at +8.
        check("pv_latency", pv_edge, start + 8);
        send_gap();
        check_pixels("single");
        check_events("single", 1, 0, 0);

        // Three pixels back to back.
        exp_q.push_back({2'b00, 6'd0, 24'hA5A5A5});
        exp_q.push_back({2'b00, 6'd1, 24'h123456});
        exp_q.push_back({2'b00, 6'd2, 24'hFFFFFF});
        send_pixel(24'hA5A5A5);
        send_pixel(24'h123456);
        send_pixel(24'hFFFFFF);
        send_gap();
        check_pixels("three");
        check_events("three", 1, 0, 0);
        // Outputs hold after the pulse.
        check("hold_grb", pixel_grb, 24'hFFFFFF);
        check("hold_idx", pixel_idx, 2);

        // Runt pulse in the middle of a pixel is ignored.
        exp_q.push_back({2'b00, 6'd0, 24'h3C3C3C});
        send_bits(24'h3C3C3C, 10);
        level(1'b1, 1);
        level(1'b0, 6);
        v = 24'h3C3C3C << 10;
        send_bits(v, 14);
        send_gap();
        check_pixels("glitch");
        check_events("glitch", 1, 1, 0);

        // Stuck high for 20 cycles: err_long on the 15th high cycle.
        start = pe_cnt;
        level(1'b1, 20);
        check("err_long_edge", el_edge, start + 17);
        send_gap();
        check_pixels("long_gap");
        check_events("long_gap", 0, 0, 1);
        exp_q.push_back({2'b00, 6'd0, 24'h5A5A5A});
        send_pixel(24'h5A5A5A);
        send_gap();
        check_pixels("after_long");
        check_events("after_long", 1, 0, 0);

        // Partial pixel dropped at the gap, frame_done still pulses.
        send_bits(24'hFFFFFF, 10);
        send_gap();
        check_pixels("partial");
        check_events("partial", 1, 0, 0);
        exp_q.push_back({2'b00, 6'd0, 24'h81C3E7});
        send_pixel(24'h81C3E7);
        send_gap();
        check_pixels("after_partial");
        check_events("after_partial", 1, 0, 0);

        // Reset mid-pixel.
        send_bits(24'hFFF000, 12);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("midrst_grb", pixel_grb, 0);
        check("midrst_idx", pixel_idx, 0);
        exp_q.push_back({2'b00, 6'd0, 24'h0F0F0F});
        send_pixel(24'h0F0F0F);
        send_gap();
        check_pixels("midrst");
        check_events("midrst", 1, 0, 0);

        // 65 pixels in one frame: index wraps 63 -> 0.
        for (int i = 0; i < 65; i++) begin
            v = {i[7:0], 8'(i * 7), 8'hC3};
            exp_q.push_back({2'b00, 6'(i % 64), v});
            send_pixel(v);
        end
        send_gap();
        check_pixels("wrap");
        check_events("wrap", 1, 0, 0);

        check("valid_done_overlap", coinc_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule : tb_ws2812_rx
